param_rr_arbiter: RTL and testbench

- Round-robin arbiter that shares one N:1 param_mux between N requesters.
- Drives the mux select `s` plus a one-hot grant vector.
- An owner keeps the grant for as long as it holds its request.
- Sits directly in front of param_mux; `s` connects straight to the mux select input.

---
 rtl/param_rr_arbiter.sv | 137 +++++++++++++
 tb/tb_param_rr_arbiter.sv | 128 ++++++++++++
 2 files changed

// File: rtl/param_rr_arbiter.sv
// Round-robin arbiter driving a shared N:1 mux select plus a one-hot grant vector.
// Define ARB_HOLD_LIMIT_EN to force a rotation after MAX_HOLD cycles under contention.
module param_rr_arbiter #(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] s,
  output logic                 valid
);

  localparam int unsigned SW = $clog2(N);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    gnt_q, gnt_d;
  logic [SW-1:0]   s_q, s_d;
  logic            valid_q, valid_d;
  logic [SW-1:0]   ptr_q, ptr_d;

  logic [N-1:0]    one_n;
  logic [N-1:0]    others;
  logic            owner_drop;
  logic            forced;
  logic [SW-1:0]   ptr_nxt;
  logic [SW:0]     pick;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);
  logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
`endif

  // Returns {found, index}; the lowest offset from start wins because it is assigned last.
  function automatic logic [SW:0] rr_pick(input logic [N-1:0] cand, input logic [SW-1:0] start);
    logic [SW:0]   res;
    int unsigned   idx;
    logic [SW-1:0] idx_w;
    res = '0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= N) idx = idx - N;
      idx_w = idx[SW-1:0];
      if (cand[idx_w]) res = {1'b1, idx_w};
    end
    return res;
  endfunction

  assign one_n      = {{(N-1){1'b0}}, 1'b1};
  assign others     = req & ~gnt_q;
  assign owner_drop = ~|(req & gnt_q);
  assign ptr_nxt    = (s_q == SW'(N - 1)) ? '0 : s_q + 1'b1;

`ifdef ARB_HOLD_LIMIT_EN
  assign forced = (hold_cnt_q == HoldLast) && (|others);
`else
  assign forced = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    pick    = '0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_d = hold_cnt_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (|req) pick = rr_pick(req, ptr_q);
      end
      StGrant: begin
        if (owner_drop || forced) begin
          // Owner is excluded from the scan so it can never win back immediately.
          ptr_d = ptr_nxt;
          pick  = rr_pick(others, ptr_nxt);
          if (!pick[SW]) begin
            state_d = StIdle;
            gnt_d   = '0;
            valid_d = 1'b0;
          end
        end else begin
`ifdef ARB_HOLD_LIMIT_EN
          if (hold_cnt_q != HoldLast) hold_cnt_d = hold_cnt_q + 1'b1;
`endif
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    if (pick[SW]) begin
      state_d = StGrant;
      gnt_d   = one_n << pick[SW-1:0];
      s_d     = pick[SW-1:0];
      valid_d = 1'b1;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_d = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      s_q     <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt_q <= hold_cnt_d;
`endif
    end
  end

  assign gnt   = gnt_q;
  assign s     = s_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_param_rr_arbiter.sv
// Directed vector bench for param_rr_arbiter (N=8, MAX_HOLD=4); follows ARB_HOLD_LIMIT_EN.
module tb_param_rr_arbiter;

  localparam int unsigned N = 8;

  logic       clk;
  logic       rst;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] s;
  logic       valid;

  int tests;
  int fails;

  param_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .s     (s),
    .valid (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       rst;
    logic [7:0] req;
    logic [7:0] gnt;
    logic [2:0] s;
    logic       valid;
  } vec_t;

  // Apply inputs, clock once, sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [7:0] q);
    rst = r;
    req = q;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] eg, input logic [2:0] es,
                       input logic ev);
    logic ok;
    tests++;
    ok = (gnt === eg) && (s === es) && (valid === ev);
    ok = ok && ((gnt & (gnt - 8'd1)) == 8'd0) && (valid === (|gnt));
    if (!ok) begin
      fails++;
      $display("FAIL %s: got gnt=%h s=%0d valid=%b, required gnt=%h s=%0d valid=%b",
               name, gnt, s, valid, eg, es, ev);
    end
  endtask

  vec_t vecs[$];

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b1;
    req   = 8'h00;

    vecs.push_back('{"reset0",        1'b1, 8'hFF, 8'h00, 3'd0, 1'b0});
    vecs.push_back('{"reset1",        1'b1, 8'hFF, 8'h00, 3'd0, 1'b0});
    vecs.push_back('{"first_grant",   1'b0, 8'hFF, 8'h01, 3'd0, 1'b1});
    vecs.push_back('{"reset_midgnt",  1'b1, 8'hFF, 8'h00, 3'd0, 1'b0});
    vecs.push_back('{"idle",          1'b0, 8'h00, 8'h00, 3'd0, 1'b0});
    vecs.push_back('{"single_req4",   1'b0, 8'h10, 8'h10, 3'd4, 1'b1});
    vecs.push_back('{"release4",      1'b0, 8'h00, 8'h00, 3'd4, 1'b0});
    vecs.push_back('{"scan_wrap_ptr5",1'b0, 8'h1F, 8'h01, 3'd0, 1'b1});
    vecs.push_back('{"fair_to7",      1'b0, 8'h80, 8'h80, 3'd7, 1'b1});
    vecs.push_back('{"fair_hold7",    1'b0, 8'h81, 8'h80, 3'd7, 1'b1});
    vecs.push_back('{"fair_to0",      1'b0, 8'h01, 8'h01, 3'd0, 1'b1});
    vecs.push_back('{"fair_hold0",    1'b0, 8'h81, 8'h01, 3'd0, 1'b1});
    vecs.push_back('{"fair_to7b",     1'b0, 8'h80, 8'h80, 3'd7, 1'b1});
    vecs.push_back('{"to6",           1'b0, 8'h40, 8'h40, 3'd6, 1'b1});
    vecs.push_back('{"hold6",         1'b0, 8'h41, 8'h40, 3'd6, 1'b1});
    vecs.push_back('{"wrap_6_to_0",   1'b0, 8'h01, 8'h01, 3'd0, 1'b1});
    vecs.push_back('{"to2",           1'b0, 8'h04, 8'h04, 3'd2, 1'b1});
    vecs.push_back('{"hold2_req5",    1'b0, 8'h24, 8'h04, 3'd2, 1'b1});
    vecs.push_back('{"handoff_2_to_5",1'b0, 8'h20, 8'h20, 3'd5, 1'b1});
    vecs.push_back('{"drop_all",      1'b0, 8'h00, 8'h00, 3'd5, 1'b0});
    vecs.push_back('{"idle_keeps_s",  1'b0, 8'h00, 8'h00, 3'd5, 1'b0});
    vecs.push_back('{"ptr6_pick6",    1'b0, 8'h41, 8'h40, 3'd6, 1'b1});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].req);
      check(vecs[i].name, vecs[i].gnt, vecs[i].s, vecs[i].valid);
    end

    // Sustained contention between requesters 0 and 1.
    step(1'b1, 8'h00);
    check("hold_reset", 8'h00, 3'd0, 1'b0);
    for (int c = 0; c < 100; c++) begin
      step(1'b0, 8'h03);
`ifdef ARB_HOLD_LIMIT_EN
      if (((c / 4) % 2) == 0) check("hold_limit", 8'h01, 3'd0, 1'b1);
      else                    check("hold_limit", 8'h02, 3'd1, 1'b1);
`else
      check("hold_unlimited", 8'h01, 3'd0, 1'b1);
`endif
    end

    // Lone requester keeps the grant regardless of the hold limit.
    step(1'b1, 8'h00);
    check("solo_reset", 8'h00, 3'd0, 1'b0);
    for (int c = 0; c < 20; c++) begin
      step(1'b0, 8'h01);
      check("solo_hold", 8'h01, 3'd0, 1'b1);
    end

    // Reset wins over a pending handoff.
    step(1'b0, 8'h02);
    check("handoff_0_to_1", 8'h02, 3'd1, 1'b1);
    step(1'b1, 8'h01);
    check("reset_over_handoff", 8'h00, 3'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
